// File: rtl/cache_pkg.sv
// cache_pkg: shared geometry and types for the cache write-back path.
//   WORDS    : 32-bit words per line (one data BRAM bank per word)
//   INDEX_W  : set index width
//   TAG_W    : tag width
//   OFFSET_W : byte-offset width inside a line
//   CNT_W    : width of the word counter used during the W burst
//   LINE_W   : width of the concatenated BRAM read data
//   wb_state_e : write-back FSM states
package cache_pkg;

  localparam int WORDS    = 8;
  localparam int INDEX_W  = 7;
  localparam int TAG_W    = 20;
  localparam int OFFSET_W = $clog2(WORDS * 4);
  localparam int CNT_W    = $clog2(WORDS);
  localparam int LINE_W   = WORDS * 32;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_RD     = 3'd1,
    ST_CAP    = 3'd2,
    ST_AW     = 3'd3,
    ST_W      = 3'd4,
    ST_B_WAIT = 3'd5
  } wb_state_e;

  // Line-aligned byte address of a line: byte offset is always zero.
  function automatic logic [31:0] line_addr(input logic [TAG_W-1:0]   tag,
                                            input logic [INDEX_W-1:0] index);
    return {tag, index, {OFFSET_W{1'b0}}};
  endfunction

endpackage

// File: rtl/cache_wb_unit_if.sv
// cache_wb_unit_if: AXI-style single-ID write channel (AW, W, B) between the
// write-back unit and the memory bus arbiter.
//   master : write-back unit side (drives AW/W payload, B ready)
//   slave  : memory side (drives AW/W ready, B valid)
interface cache_wb_unit_if;

  logic        mem_aw_valid;
  logic        mem_aw_ready;
  logic [31:0] mem_aw_addr;
  logic [7:0]  mem_aw_len;
  logic        mem_w_valid;
  logic        mem_w_ready;
  logic [31:0] mem_w_data;
  logic        mem_w_last;
  logic        mem_b_valid;
  logic        mem_b_ready;

  modport master (
    output mem_aw_valid, mem_aw_addr, mem_aw_len,
    input  mem_aw_ready,
    output mem_w_valid, mem_w_data, mem_w_last,
    input  mem_w_ready,
    input  mem_b_valid,
    output mem_b_ready
  );

  modport slave (
    input  mem_aw_valid, mem_aw_addr, mem_aw_len,
    output mem_aw_ready,
    input  mem_w_valid, mem_w_data, mem_w_last,
    output mem_w_ready,
    output mem_b_valid,
    input  mem_b_ready
  );

endinterface

// File: rtl/cache_line_buf.sv
// cache_line_buf: WORDS x 32 register file holding one evicted line.
//   clk, rst  : clock, asynchronous active-high reset (clears all words)
//   load      : capture load_data into every word in parallel
//   load_data : concatenated line, word i at [32i+31:32i]
//   sel       : word select for the read side
//   word      : selected word (combinational read)
module cache_line_buf
  import cache_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [LINE_W-1:0] load_data,
  input  logic [CNT_W-1:0]  sel,
  output logic [31:0]       word
);

  logic [WORDS-1:0][31:0] words;

  generate
    for (genvar gi = 0; gi < WORDS; gi++) begin : g_word
      logic [31:0] word_reg;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          word_reg <= '0;
        end else if (load) begin
          word_reg <= load_data[32*gi +: 32];
        end
      end

      assign words[gi] = word_reg;
    end
  endgenerate

  assign word = words[sel];

endmodule

// File: rtl/cache_wb_unit.sv
// cache_wb_unit: evicts one dirty line to memory.
// Reads every data bank of the victim line through BRAM port b, snapshots the
// line into a local buffer, then writes it out as a single AXI-style burst.
//   clk, rst        : clock, asynchronous active-high reset
//   wb_req_valid/ready, wb_index, wb_tag : eviction request from cache control
//   bram_rd_index   : addrb of every data bank (registered, held RD..B_WAIT)
//   bram_rd_data    : concatenated doutb of all banks, valid one cycle after RD
//   busy, busy_index, busy_tag : line currently in flight (refill hazard check)
//   mem             : AW/W/B write channel to the memory arbiter
//   wb_done         : one-cycle pulse on the B handshake
module cache_wb_unit
  import cache_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               wb_req_valid,
  output logic               wb_req_ready,
  input  logic [INDEX_W-1:0] wb_index,
  input  logic [TAG_W-1:0]   wb_tag,
  output logic [INDEX_W-1:0] bram_rd_index,
  input  logic [LINE_W-1:0]  bram_rd_data,
  output logic               busy,
  output logic [INDEX_W-1:0] busy_index,
  output logic [TAG_W-1:0]   busy_tag,
  cache_wb_unit_if.master    mem,
  output logic               wb_done
);

  wb_state_e          state_reg, state_next;
  logic [CNT_W-1:0]   cnt_reg, cnt_next;
  logic [INDEX_W-1:0] index_reg;
  logic [TAG_W-1:0]   tag_reg;
  logic               accept;
  logic               buf_load;
  logic [31:0]        buf_word;

  assign accept = (state_reg == ST_IDLE) && wb_req_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= '0;
      index_reg <= '0;
      tag_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      // Index/tag only move on accept, so the BRAM address and the hazard
      // outputs stay frozen for the whole eviction.
      if (accept) begin
        index_reg <= wb_index;
        tag_reg   <= wb_tag;
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    buf_load   = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (wb_req_valid) state_next = ST_RD;
      end
      ST_RD: begin
        // BRAM samples bram_rd_index at the end of this cycle.
        state_next = ST_CAP;
      end
      ST_CAP: begin
        // doutb is valid now; snapshot so later port-a writes cannot leak in.
        buf_load   = 1'b1;
        state_next = ST_AW;
      end
      ST_AW: begin
        if (mem.mem_aw_ready) state_next = ST_W;
      end
      ST_W: begin
        if (mem.mem_w_ready) begin
          if (cnt_reg == CNT_W'(WORDS - 1)) begin
            cnt_next   = '0;
            state_next = ST_B_WAIT;
          end else begin
            cnt_next = cnt_reg + 1'b1;
          end
        end
      end
      ST_B_WAIT: begin
        if (mem.mem_b_valid) state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  cache_line_buf u_line_buf (
    .clk       (clk),
    .rst       (rst),
    .load      (buf_load),
    .load_data (bram_rd_data),
    .sel       (cnt_reg),
    .word      (buf_word)
  );

  // All outputs decode from registered state so none depends on a ready input.
  assign wb_req_ready  = (state_reg == ST_IDLE);
  assign busy          = (state_reg != ST_IDLE);
  assign busy_index    = index_reg;
  assign busy_tag      = tag_reg;
  assign bram_rd_index = index_reg;

  assign mem.mem_aw_valid = (state_reg == ST_AW);
  assign mem.mem_aw_addr  = line_addr(tag_reg, index_reg);
  assign mem.mem_aw_len   = 8'(WORDS - 1);
  assign mem.mem_w_valid  = (state_reg == ST_W);
  assign mem.mem_w_data   = buf_word;
  assign mem.mem_w_last   = (cnt_reg == CNT_W'(WORDS - 1));
  assign mem.mem_b_ready  = (state_reg == ST_B_WAIT);

  // Pulses in the handshake cycle itself; the response code is not examined.
  assign wb_done = (state_reg == ST_B_WAIT) && mem.mem_b_valid;

endmodule

// File: tb/tb_cache_wb_unit.sv
// tb_cache_wb_unit: randomized self-checking bench for cache_wb_unit.
// A line-array BRAM model feeds port b; the bench acts as the memory slave and
// predicts every AW/W/B event from the line contents at request time.
module tb_cache_wb_unit;
  import cache_pkg::*;

  logic               clk = 1'b0;
  logic               rst;
  logic               wb_req_valid;
  logic               wb_req_ready;
  logic [INDEX_W-1:0] wb_index;
  logic [TAG_W-1:0]   wb_tag;
  logic [INDEX_W-1:0] bram_rd_index;
  logic [LINE_W-1:0]  bram_rd_data;
  logic               busy;
  logic [INDEX_W-1:0] busy_index;
  logic [TAG_W-1:0]   busy_tag;
  logic               wb_done;

  cache_wb_unit_if mem_bus ();

  always #5 clk = ~clk;

  cache_wb_unit dut (
    .clk           (clk),
    .rst           (rst),
    .wb_req_valid  (wb_req_valid),
    .wb_req_ready  (wb_req_ready),
    .wb_index      (wb_index),
    .wb_tag        (wb_tag),
    .bram_rd_index (bram_rd_index),
    .bram_rd_data  (bram_rd_data),
    .busy          (busy),
    .busy_index    (busy_index),
    .busy_tag      (busy_tag),
    .mem           (mem_bus),
    .wb_done       (wb_done)
  );

  // Data BRAM: one bank per word, registered read on port b.
  logic [31:0] bram_arr [0:127][0:WORDS-1];

  always @(posedge clk) begin
    for (int i = 0; i < WORDS; i++)
      bram_rd_data[32*i +: 32] <= bram_arr[bram_rd_index][i];
  end

  int n_pass   = 0;
  int n_checks = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", tag, got, exp);
  endtask

  // One eviction with the bench playing memory.
  //   wmode: 0 W always ready, 1 ready toggles 1,0,..., 2 random
  //   corrupt: overwrite the BRAM line after the capture cycle
  //   hold_next: keep a request (nidx/ntag) pending through this eviction
  //   expect_now: previous call left a pending request; accept must be immediate
  //   abort_beat: >=0 asserts reset while that W beat is presented
  task automatic run_evict(input logic [INDEX_W-1:0] idx, input logic [TAG_W-1:0] tag,
                           input int wmode, input int aw_stall, input int b_delay,
                           input bit corrupt, input bit hold_next,
                           input logic [INDEX_W-1:0] nidx, input logic [TAG_W-1:0] ntag,
                           input bit expect_now, input int abort_beat);
    logic [31:0] exp_w [WORDS];
    logic [31:0] exp_addr;
    int t, cyc, beat, aw_wait, b_wait, done_cyc;
    bit aw_done, finished, w_tog;

    for (int i = 0; i < WORDS; i++) exp_w[i] = bram_arr[idx][i];
    exp_addr = {tag, idx, {OFFSET_W{1'b0}}};

    if (!expect_now) @(negedge clk);
    wb_req_valid = 1'b1;
    wb_index     = idx;
    wb_tag       = tag;
    t = 0;
    while (!wb_req_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    check_eq("req_ready", 64'(wb_req_ready), 64'(1'b1));
    if (expect_now) check_eq("b2b_accept_delay", 64'(t), 64'(0));

    cyc = 0; beat = 0; aw_wait = 0; b_wait = 0; done_cyc = -1;
    aw_done = 1'b0; finished = 1'b0; w_tog = 1'b1;

    while (!finished && cyc < 500) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) begin
        if (hold_next) begin
          wb_index = nidx;
          wb_tag   = ntag;
        end else begin
          wb_req_valid = 1'b0;
        end
      end
      mem_bus.mem_aw_ready = 1'b0;
      mem_bus.mem_w_ready  = 1'b0;
      mem_bus.mem_b_valid  = 1'b0;

      check_eq("busy", 64'(busy), 64'(1'b1));
      check_eq("req_ready_busy", 64'(wb_req_ready), 64'(1'b0));
      check_eq("busy_index", 64'(busy_index), 64'(idx));
      check_eq("busy_tag", 64'(busy_tag), 64'(tag));
      check_eq("bram_rd_index", 64'(bram_rd_index), 64'(idx));

      if (corrupt && cyc == 3)
        for (int i = 0; i < WORDS; i++) bram_arr[idx][i] = ~exp_w[i];

      if (abort_beat >= 0 && mem_bus.mem_w_valid && beat == abort_beat) begin
        rst = 1'b1;
        #1;
        check_eq("rst_aw_valid", 64'(mem_bus.mem_aw_valid), 64'(1'b0));
        check_eq("rst_w_valid", 64'(mem_bus.mem_w_valid), 64'(1'b0));
        check_eq("rst_b_ready", 64'(mem_bus.mem_b_ready), 64'(1'b0));
        check_eq("rst_busy", 64'(busy), 64'(1'b0));
        check_eq("rst_wb_done", 64'(wb_done), 64'(1'b0));
        check_eq("rst_req_ready", 64'(wb_req_ready), 64'(1'b1));
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_eq("post_rst_ready", 64'(wb_req_ready), 64'(1'b1));
        check_eq("post_rst_busy", 64'(busy), 64'(1'b0));
        $display("evict idx=%h tag=%h aborted by reset at beat %0d", idx, tag, beat);
        return;
      end

      if (mem_bus.mem_aw_valid) begin
        check_eq("aw_once", 64'(aw_done), 64'(1'b0));
        check_eq("aw_addr", 64'(mem_bus.mem_aw_addr), 64'(exp_addr));
        check_eq("aw_len", 64'(mem_bus.mem_aw_len), 64'(WORDS - 1));
        mem_bus.mem_aw_ready = (aw_wait >= aw_stall);
        aw_wait++;
        if (mem_bus.mem_aw_ready) aw_done = 1'b1;
      end

      if (mem_bus.mem_w_valid) begin
        check_eq("w_after_aw", 64'(aw_done), 64'(1'b1));
        check_eq("w_in_range", 64'(beat < WORDS), 64'(1'b1));
        check_eq("w_data", 64'(mem_bus.mem_w_data), 64'(exp_w[beat % WORDS]));
        check_eq("w_last", 64'(mem_bus.mem_w_last), 64'(beat == WORDS - 1));
        case (wmode)
          0:       mem_bus.mem_w_ready = 1'b1;
          1: begin mem_bus.mem_w_ready = w_tog; w_tog = ~w_tog; end
          default: mem_bus.mem_w_ready = 1'($urandom_range(0, 1));
        endcase
        if (mem_bus.mem_w_ready) beat++;
      end

      if (mem_bus.mem_b_ready) begin
        check_eq("b_after_all_beats", 64'(beat), 64'(WORDS));
        mem_bus.mem_b_valid = (b_wait >= b_delay);
        b_wait++;
      end

      #1;
      check_eq("wb_done", 64'(wb_done), 64'(mem_bus.mem_b_valid));
      if (mem_bus.mem_b_valid) begin
        done_cyc = cyc;
        finished = 1'b1;
      end
    end

    check_eq("evict_finished", 64'(finished), 64'(1'b1));
    if (wmode == 0 && aw_stall == 0 && b_delay == 0)
      check_eq("latency", 64'(done_cyc), 64'(WORDS + 4));

    @(negedge clk);
    mem_bus.mem_aw_ready = 1'b0;
    mem_bus.mem_w_ready  = 1'b0;
    mem_bus.mem_b_valid  = 1'b0;
    #1;
    check_eq("done_pulse_end", 64'(wb_done), 64'(1'b0));
    check_eq("idle_busy", 64'(busy), 64'(1'b0));
    check_eq("idle_ready", 64'(wb_req_ready), 64'(1'b1));
    check_eq("idle_b_ready", 64'(mem_bus.mem_b_ready), 64'(1'b0));
    $display("evict idx=%h tag=%h wmode=%0d aw_stall=%0d b_delay=%0d done_cycle=%0d",
             idx, tag, wmode, aw_stall, b_delay, done_cyc);
  endtask

  initial begin
    rst          = 1'b1;
    wb_req_valid = 1'b0;
    wb_index     = '0;
    wb_tag       = '0;
    mem_bus.mem_aw_ready = 1'b0;
    mem_bus.mem_w_ready  = 1'b0;
    mem_bus.mem_b_valid  = 1'b0;
    for (int s = 0; s < 128; s++)
      for (int i = 0; i < WORDS; i++) bram_arr[s][i] = $urandom;
    for (int i = 0; i < WORDS; i++) bram_arr[7'h05][i] = 32'h1000_0000 + i;

    @(negedge clk);
    @(negedge clk);
    check_eq("reset_ready", 64'(wb_req_ready), 64'(1'b1));
    check_eq("reset_busy", 64'(busy), 64'(1'b0));
    check_eq("reset_aw_valid", 64'(mem_bus.mem_aw_valid), 64'(1'b0));
    check_eq("reset_w_valid", 64'(mem_bus.mem_w_valid), 64'(1'b0));
    check_eq("reset_b_ready", 64'(mem_bus.mem_b_ready), 64'(1'b0));
    check_eq("reset_wb_done", 64'(wb_done), 64'(1'b0));
    check_eq("reset_rd_index", 64'(bram_rd_index), 64'(0));
    check_eq("reset_busy_tag", 64'(busy_tag), 64'(0));
    rst = 1'b0;

    // Single eviction, all readies high.
    run_evict(7'h05, 20'hABCDE, 0, 0, 0, 1'b0, 1'b0, '0, '0, 1'b0, -1);
    // W backpressure toggling 1,0.
    run_evict(7'h09, 20'h12345, 1, 0, 0, 1'b0, 1'b0, '0, '0, 1'b0, -1);
    // AW stalled 5 cycles, B delayed 3.
    run_evict(7'h0C, 20'h0F0F0, 0, 5, 3, 1'b0, 1'b0, '0, '0, 1'b0, -1);
    // Back-to-back with a pending request held during the first eviction.
    run_evict(7'h11, 20'h11111, 2, 2, 1, 1'b0, 1'b1, 7'h22, 20'h22222, 1'b0, -1);
    run_evict(7'h22, 20'h22222, 0, 0, 0, 1'b0, 1'b0, '0, '0, 1'b1, -1);
    // Reset during beat 3, then a clean eviction of the same line.
    run_evict(7'h33, 20'h33333, 0, 0, 0, 1'b0, 1'b0, '0, '0, 1'b0, 3);
    run_evict(7'h33, 20'h33333, 0, 0, 0, 1'b0, 1'b0, '0, '0, 1'b0, -1);
    // BRAM line rewritten after capture: snapshot must go out.
    run_evict(7'h44, 20'h44444, 1, 1, 1, 1'b1, 1'b0, '0, '0, 1'b0, -1);

    for (int n = 0; n < 12; n++) begin
      run_evict(7'($urandom_range(0, 127)), 20'($urandom), int'($urandom_range(0, 2)),
                int'($urandom_range(0, 4)), int'($urandom_range(0, 4)),
                1'($urandom_range(0, 1)), 1'b0, '0, '0, 1'b0, -1);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
